safety_obi_reg_bridge: RTL and testbench

//  Bridges the safety core data port (req/gnt/rvalid protocol) onto the register bus

---
 rtl/safety_obi_reg_bridge.sv | 153 +++++++++++++++
 tb/tb_safety_obi_reg_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/safety_obi_reg_bridge.sv
// Safety core data port (req/gnt/rvalid) to register bus bridge with window decode and hang timeout.
// One access outstanding; in-window response 2+ cycles after grant, out-of-window 1 cycle; grant only in IDLE/RESP.
module safety_obi_reg_bridge #(
  parameter logic [31:0] BaseAddr      = 32'h0002_0000,
  parameter logic [31:0] RegionSize    = 32'h0000_1000,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TimeoutCycles = 16,
  parameter logic [31:0] ErrRdata      = 32'hBADCAB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o,
  output logic                 reg_valid_o,
  output logic                 reg_write_o,
  output logic [AddrWidth-1:0] reg_addr_o,
  output logic [31:0]          reg_wdata_o,
  output logic [3:0]           reg_wstrb_o,
  input  logic [31:0]          reg_rdata_i,
  input  logic                 reg_error_i,
  input  logic                 reg_ready_i,
  output logic                 timeout_o
);

  localparam int unsigned    CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;
  localparam logic [31:0]    EndAddr = BaseAddr + RegionSize;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [AddrWidth-1:0]  off_q, off_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  accept;
  logic                  in_win;
  logic                  timeout_hit;
  logic [31:0]           win_off;

  always_comb begin
    in_win  = (data_addr_i >= BaseAddr) && (data_addr_i < EndAddr);
    win_off = (data_addr_i - BaseAddr) & ~32'h3;
    // A request seen while reset is asserted would be dropped, so never grant it.
    accept  = data_req_i && ((state_q == IDLE) || (state_q == RESP)) && !rst_i;

    state_d     = state_q;
    we_d        = we_q;
    be_d        = be_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      BUSY: begin
        if (reg_ready_i) begin
          rdata_d = we_q ? 32'h0 : reg_rdata_i;
          err_d   = reg_error_i;
          state_d = RESP;
        end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
          timeout_hit = 1'b1;
          rdata_d     = we_q ? 32'h0 : ErrRdata;
          err_d       = 1'b1;
          state_d     = RESP;
        end else if (TimeoutCycles != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accept only happens in IDLE/RESP, so it never competes with the BUSY branch.
    if (accept) begin
      we_d    = data_we_i;
      be_d    = data_be_i;
      off_d   = AddrWidth'(win_off);
      wdata_d = data_wdata_i;
      if (in_win) begin
        state_d = BUSY;
        cnt_d   = '0;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end else begin
        state_d = RESP;
        rdata_d = data_we_i ? 32'h0 : ErrRdata;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      be_q    <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      be_q    <= be_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response and reg-bus fields are gated so they read as zero outside their phase.
  always_comb begin
    data_gnt_o    = accept;
    data_rvalid_o = (state_q == RESP);
    data_rdata_o  = data_rvalid_o ? rdata_q : 32'h0;
    data_err_o    = data_rvalid_o & err_q;
    reg_valid_o   = (state_q == BUSY);
    reg_write_o   = reg_valid_o & we_q;
    reg_addr_o    = reg_valid_o ? off_q : '0;
    reg_wdata_o   = reg_valid_o ? wdata_q : 32'h0;
    reg_wstrb_o   = reg_valid_o ? be_q : 4'h0;
    timeout_o     = timeout_hit;
  end

endmodule

// File: tb/tb_safety_obi_reg_bridge.sv
// Directed bench for safety_obi_reg_bridge: expected responses queued at grant, checked by a monitor on rvalid.
module tb_safety_obi_reg_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        reg_valid_o;
  logic        reg_write_o;
  logic [31:0] reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_wstrb_o;
  logic [31:0] reg_rdata_i;
  logic        reg_error_i;
  logic        reg_ready_i;
  logic        timeout_o;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_tmo = 0;

  always #5 clk_i = ~clk_i;

  safety_obi_reg_bridge dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_req_i   (data_req_i),
    .data_gnt_o   (data_gnt_o),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .data_err_o   (data_err_o),
    .reg_valid_o  (reg_valid_o),
    .reg_write_o  (reg_write_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_wstrb_o  (reg_wstrb_o),
    .reg_rdata_i  (reg_rdata_i),
    .reg_error_i  (reg_error_i),
    .reg_ready_i  (reg_ready_i),
    .timeout_o    (timeout_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected response per rvalid; response fields must be zero otherwise.
  always @(negedge clk_i) begin
    rsp_t e;
    if (timeout_o === 1'b1) n_tmo++;
    if (data_rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rvalid: got rdata %h err %b with no response expected", data_rdata_o, data_err_o);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", data_rdata_o, e.rdata);
        chk("rsp_err", {31'b0, data_err_o}, {31'b0, e.err});
      end
    end else begin
      chk("idle_rdata", data_rdata_o, 32'h0);
      chk("idle_err", {31'b0, data_err_o}, 32'h0);
    end
  end

  task automatic outs_zero(input string tag);
    chk({tag, "_gnt"}, {31'b0, data_gnt_o}, 32'h0);
    chk({tag, "_rvalid"}, {31'b0, data_rvalid_o}, 32'h0);
    chk({tag, "_reg_valid"}, {31'b0, reg_valid_o}, 32'h0);
    chk({tag, "_reg_write"}, {31'b0, reg_write_o}, 32'h0);
    chk({tag, "_reg_addr"}, reg_addr_o, 32'h0);
    chk({tag, "_reg_wdata"}, reg_wdata_o, 32'h0);
    chk({tag, "_reg_wstrb"}, {28'b0, reg_wstrb_o}, 32'h0);
    chk({tag, "_timeout"}, {31'b0, timeout_o}, 32'h0);
  endtask

  // Entered just after a rising edge; delay = BUSY cycle carrying reg_ready_i, negative = never ready.
  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input int delay,
                        input logic [31:0] rsp_rdata, input logic rsp_err, input logic inwin,
                        input logic [31:0] exp_off, input logic [31:0] exp_rdata, input logic exp_err);
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_addr_i  = addr;
    data_be_i    = be;
    data_wdata_i = wdata;
    @(negedge clk_i);
    chk("gnt", {31'b0, data_gnt_o}, 32'h1);
    exp_q.push_back(rsp_t'{exp_rdata, exp_err});
    @(posedge clk_i); #1;
    data_req_i = 1'b0;
    if (inwin) begin
      for (int n = 1; n <= 40; n++) begin
        if (n == delay) begin
          reg_ready_i = 1'b1;
          reg_rdata_i = rsp_rdata;
          reg_error_i = rsp_err;
        end
        @(negedge clk_i);
        chk("reg_valid", {31'b0, reg_valid_o}, 32'h1);
        chk("reg_addr", reg_addr_o, exp_off);
        chk("reg_write", {31'b0, reg_write_o}, {31'b0, we});
        chk("reg_wdata", reg_wdata_o, wdata);
        chk("reg_wstrb", {28'b0, reg_wstrb_o}, {28'b0, be});
        chk("timeout", {31'b0, timeout_o}, (delay < 0 && n == 16) ? 32'h1 : 32'h0);
        @(posedge clk_i); #1;
        reg_ready_i = 1'b0;
        reg_rdata_i = 32'h0;
        reg_error_i = 1'b0;
        if (n == delay || (delay < 0 && n == 16)) break;
      end
    end
    @(negedge clk_i);
    chk("rvalid_latency", {31'b0, data_rvalid_o}, 32'h1);
    chk("reg_valid_in_resp", {31'b0, reg_valid_o}, 32'h0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i        = 1'b1;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
    reg_rdata_i  = 32'h0;
    reg_error_i  = 1'b0;
    reg_ready_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    outs_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Read inside window, ready in first BUSY cycle.
    access(1'b0, 32'h0002_0010, 4'hF, 32'h0, 1, 32'hCAFE_0001, 1'b0, 1'b1,
           32'h10, 32'hCAFE_0001, 1'b0);
    // Write with reg-bus error: data forced to 0, error passed through.
    access(1'b1, 32'h0002_0004, 4'b0011, 32'h1234_5678, 1, 32'hFFFF_FFFF, 1'b1, 1'b1,
           32'h4, 32'h0, 1'b1);
    // Out-of-window read and write, including both window edges.
    access(1'b0, 32'h0003_0000, 4'hF, 32'h0, 0, 32'h0, 1'b0, 1'b0,
           32'h0, 32'hBADC_AB1E, 1'b1);
    access(1'b0, 32'h0002_1000, 4'hF, 32'h0, 0, 32'h0, 1'b0, 1'b0,
           32'h0, 32'hBADC_AB1E, 1'b1);
    access(1'b1, 32'h0001_FFFC, 4'hF, 32'hAAAA_5555, 0, 32'h0, 1'b0, 1'b0,
           32'h0, 32'h0, 1'b1);
    // Last word of the window, unaligned address, slower ready.
    access(1'b0, 32'h0002_0FFC, 4'hF, 32'h0, 3, 32'h0BAD_F00D, 1'b0, 1'b1,
           32'hFFC, 32'h0BAD_F00D, 1'b0);
    access(1'b0, 32'h0002_0013, 4'b1000, 32'h0, 2, 32'h5A5A_A5A5, 1'b0, 1'b1,
           32'h10, 32'h5A5A_A5A5, 1'b0);
    // Hung peripheral: 16 BUSY cycles then abort.
    access(1'b0, 32'h0002_0100, 4'hF, 32'h0, -1, 32'h0, 1'b0, 1'b1,
           32'h100, 32'hBADC_AB1E, 1'b1);

    // Back-to-back: request held high, second grant in first rvalid cycle.
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_be_i   = 4'hF;
    data_addr_i = 32'h0002_0020;
    @(negedge clk_i);
    chk("b2b_gnt1", {31'b0, data_gnt_o}, 32'h1);
    exp_q.push_back(rsp_t'{32'h1111_0001, 1'b0});
    @(posedge clk_i); #1;
    data_addr_i = 32'h0002_0024;
    reg_ready_i = 1'b1;
    reg_rdata_i = 32'h1111_0001;
    @(negedge clk_i);
    chk("b2b_nogrant_busy", {31'b0, data_gnt_o}, 32'h0);
    chk("b2b_addr1", reg_addr_o, 32'h20);
    @(posedge clk_i); #1;
    reg_ready_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_rvalid1", {31'b0, data_rvalid_o}, 32'h1);
    chk("b2b_gnt2", {31'b0, data_gnt_o}, 32'h1);
    exp_q.push_back(rsp_t'{32'h2222_0002, 1'b0});
    @(posedge clk_i); #1;
    data_req_i  = 1'b0;
    reg_ready_i = 1'b1;
    reg_rdata_i = 32'h2222_0002;
    @(negedge clk_i);
    chk("b2b_gap", {31'b0, data_rvalid_o}, 32'h0);
    chk("b2b_addr2", reg_addr_o, 32'h24);
    @(posedge clk_i); #1;
    reg_ready_i = 1'b0;
    reg_rdata_i = 32'h0;
    @(negedge clk_i);
    chk("b2b_rvalid2", {31'b0, data_rvalid_o}, 32'h1);
    @(posedge clk_i); #1;

    // Reset while BUSY: the in-flight read is dropped without a response.
    data_req_i  = 1'b1;
    data_addr_i = 32'h0002_0008;
    @(negedge clk_i);
    chk("rst_busy_gnt", {31'b0, data_gnt_o}, 32'h1);
    @(posedge clk_i); #1;
    data_req_i = 1'b0;
    rst_i      = 1'b1;
    @(negedge clk_i);
    chk("rst_busy_reg_valid", {31'b0, reg_valid_o}, 32'h1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    outs_zero("after_rst");
    @(posedge clk_i); #1;
    access(1'b0, 32'h0002_0008, 4'hF, 32'h0, 1, 32'h7777_8888, 1'b0, 1'b1,
           32'h8, 32'h7777_8888, 1'b0);

    repeat (3) @(posedge clk_i);
    #1;
    chk("timeout_pulses", n_tmo, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
